word_serializer: RTL

Serial transmitter for the LittleComputer 16-bit datapath. It is the read-out counterpart of the parallel-load register: it captures a parallel word on LOAD and drives it out one bit at a time on a single TX line. The frame is UART-style: one start bit (0), WIDTH data bits LSB first, then one stop bit (1). It sits between a register or RAM output and an off-chip or debug serial link.

---
 rtl/word_serializer_pkg.sv | 14 +
 rtl/word_serializer_bit_timer.sv | 35 +++
 rtl/word_serializer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/word_serializer_pkg.sv
// Shared definitions for the word serializer: FSM state encoding and line levels.
package word_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic TX_IDLE_LVL  = 1'b1;
    localparam logic TX_START_LVL = 1'b0;

endpackage

// File: rtl/word_serializer_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of each bit period with a combinational tick.
module word_serializer_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic CLK,
    input  logic RESET,
    input  logic i_en,
    input  logic i_restart,
    output logic o_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;

    // The terminal compare is equality, so CLKS_PER_BIT=1 ticks every enabled cycle
    // and the counter never has to count below zero.
    assign o_tick = i_en && (r_cnt == LAST);

    // Free-running count within a bit period, cleared on reset, restart or terminal count.
    always_ff @(posedge CLK) begin
        if (RESET || i_restart) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (r_cnt == LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/word_serializer.sv
// UART-style word serializer: start bit, WIDTH data bits LSB first, stop bit.
// TX, BUSY and DONE are registered from the next-state values so they change
// on the same edge as the state they describe.
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] IN,
    input  logic             LOAD,
    output logic             TX,
    output logic             BUSY,
    output logic             DONE
);

    localparam int BCW = $clog2(WIDTH) + 1;
    localparam logic [BCW-1:0] BC_LAST = BCW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [BCW-1:0]   r_bitcnt;
    logic             r_tx;
    logic             r_busy;
    logic             r_done;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [BCW-1:0]   w_bitcnt_nxt;
    logic             w_tx_nxt;
    logic             w_done_nxt;
    logic             w_tick;
    logic             w_idle;

    assign w_idle = (r_state == IDLE);

    // The timer sits cleared while idle so the start bit always gets a full period.
    word_serializer_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .CLK      (CLK),
        .RESET    (RESET),
        .i_en     (!w_idle),
        .i_restart(w_idle),
        .o_tick   (w_tick)
    );

    // Next-state, shift register and bit counter update; LOAD only matters in IDLE.
    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_bitcnt_nxt = r_bitcnt;
        w_done_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (LOAD) begin
                    w_shift_nxt  = IN;
                    w_bitcnt_nxt = '0;
                    w_state_nxt  = START;
                end
            end
            START: begin
                if (w_tick) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_shift_nxt = {1'b0, r_shift[WIDTH-1:1]};
                    if (r_bitcnt == BC_LAST) begin
                        w_bitcnt_nxt = '0;
                        w_state_nxt  = STOP;
                    end else begin
                        w_bitcnt_nxt = r_bitcnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Line level that the next state will drive.
    always_comb begin
        w_tx_nxt = TX_IDLE_LVL;
        case (w_state_nxt)
            START:   w_tx_nxt = TX_START_LVL;
            DATA:    w_tx_nxt = w_shift_nxt[0];
            default: w_tx_nxt = TX_IDLE_LVL;
        endcase
    end

    // State and registered outputs; reset aborts any frame without pulsing DONE.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_tx     <= TX_IDLE_LVL;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_tx     <= w_tx_nxt;
            r_busy   <= (w_state_nxt != IDLE);
            r_done   <= w_done_nxt;
        end
    end

    assign TX   = r_tx;
    assign BUSY = r_busy;
    assign DONE = r_done;

endmodule
